instr_receiver_mc: RTL and testbench

- Parametrised multi-source instruction receiver.
- Arbitrates NUM_SRC instruction sources (host app, maintenance, refresh engines, ...) into one instruction sequence (iseq) at a time.
- Distributes accepted words round-robin over NUM_FIFOS instruction FIFOs, then pulses process_iseq to the dispatcher.
- Sits between the host/maintenance front-ends and the per-lane instruction FIFOs feeding the DDR dispatcher.

---
 rtl/instr_receiver_mc_if.sv | 34 +++
 rtl/instr_receiver_mc.sv | 130 +++++++++++++
 tb/tb_instr_receiver_mc.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_receiver_mc_if.sv
// rtl/instr_receiver_mc_if.sv - source handshake, FIFO write and iseq completion bundle
interface instr_receiver_mc_if #(
    parameter int INSTR_W   = 32,
    parameter int NUM_SRC   = 2,
    parameter int NUM_FIFOS = 2,
    parameter int LEN_W     = 10
);
    logic                       dispatcher_ready;
    logic                       rdback_fifo_empty;
    logic [NUM_SRC-1:0]         src_en;
    logic [NUM_SRC-1:0]         src_ack;
    logic [NUM_SRC*INSTR_W-1:0] src_instr;
    logic [NUM_FIFOS-1:0]       fifo_en;
    logic [INSTR_W-1:0]         fifo_data;
    logic [NUM_FIFOS-1:0]       fifo_full;
    logic [INSTR_W-1:0]         issued_instr;
    logic [NUM_SRC-1:0]         issued_src;
    logic                       process_iseq;
    logic [NUM_SRC-1:0]         process_iseq_src;
    logic [LEN_W-1:0]           iseq_len;
    logic                       iseq_overflow;

    modport master (
        output dispatcher_ready, rdback_fifo_empty, src_en, src_instr, fifo_full,
        input  src_ack, fifo_en, fifo_data, issued_instr, issued_src,
        input  process_iseq, process_iseq_src, iseq_len, iseq_overflow
    );

    modport slave (
        input  dispatcher_ready, rdback_fifo_empty, src_en, src_instr, fifo_full,
        output src_ack, fifo_en, fifo_data, issued_instr, issued_src,
        output process_iseq, process_iseq_src, iseq_len, iseq_overflow
    );
endinterface

// File: rtl/instr_receiver_mc.sv
// rtl/instr_receiver_mc.sv - multi-source iseq receiver, round-robin FIFO writer
// Optional INSTR_RECV_RR_ARB_EN: round-robin start arbitration (default fixed priority).
module instr_receiver_mc #(
    parameter int                 INSTR_W      = 32,
    parameter int                 NUM_SRC      = 2,
    parameter int                 NUM_FIFOS    = 2,
    parameter logic [3:0]         END_OPCODE   = 4'h4,
    parameter logic [NUM_SRC-1:0] FWD_END_MASK = NUM_SRC'(1),
    parameter int                 LEN_W        = 10
) (
    input logic              clk,
    input logic              rst,
    instr_receiver_mc_if.slave bus
);
    localparam int SIW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int FIW = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1;
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;
    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    logic [0:0]         state;
    logic [SIW-1:0]     owner;
    logic [SIW-1:0]     win_idx;
    logic [SIW-1:0]     acc_idx;
    logic               win_found;
    logic [FIW-1:0]     ptr;
    logic [LEN_W-1:0]   len_cnt;
    logic [LEN_W-1:0]   len_inc;
    logic               rdback_empty_r;
    logic               any_full;
    logic               start;
    logic               acc;
    logic               acc_end;
    logic               acc_fwd;
    logic [INSTR_W-1:0] acc_word;
`ifdef INSTR_RECV_RR_ARB_EN
    logic [SIW-1:0]     rr_base;
`endif

    assign any_full = |bus.fifo_full;
    // process_iseq blocks a new start so the dispatcher sees one completion per iseq
    assign start = (state == S_IDLE) && bus.dispatcher_ready && !bus.process_iseq &&
                   rdback_empty_r && !any_full && (|bus.src_en);

    always_comb begin
        int idx;
        idx       = 0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
`ifdef INSTR_RECV_RR_ARB_EN
            idx = (int'(rr_base) + k) % NUM_SRC;
`else
            idx = k;
`endif
            if (!win_found && bus.src_en[idx]) begin
                win_found = 1'b1;
                win_idx   = SIW'(idx);
            end
        end
    end

    always_comb begin
        bus.src_ack = '0;
        if (start)
            bus.src_ack[win_idx] = 1'b1;
        else if (state == S_BUSY && !any_full)
            bus.src_ack[owner] = bus.src_en[owner];
    end

    assign acc      = |bus.src_ack;
    assign acc_idx  = (state == S_IDLE) ? win_idx : owner;
    assign acc_word = bus.src_instr[int'(acc_idx)*INSTR_W +: INSTR_W];
    assign acc_end  = acc && (acc_word[INSTR_W-1 -: 4] == END_OPCODE);
    assign acc_fwd  = acc && (!acc_end || FWD_END_MASK[acc_idx]);
    assign len_inc  = (len_cnt == LEN_MAX) ? LEN_MAX : len_cnt + 1'b1;

    assign bus.issued_instr = bus.fifo_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= S_IDLE;
            owner                <= '0;
            ptr                  <= '0;
            len_cnt              <= '0;
            rdback_empty_r       <= 1'b1;
            bus.fifo_en          <= '0;
            bus.fifo_data        <= '0;
            bus.issued_src       <= '0;
            bus.process_iseq     <= 1'b0;
            bus.process_iseq_src <= '0;
            bus.iseq_len         <= '0;
            bus.iseq_overflow    <= 1'b0;
`ifdef INSTR_RECV_RR_ARB_EN
            rr_base              <= '0;
`endif
        end else begin
            rdback_empty_r       <= bus.rdback_fifo_empty;
            bus.fifo_en          <= '0;
            bus.fifo_data        <= '0;
            bus.issued_src       <= '0;
            bus.process_iseq     <= acc_end;
            bus.process_iseq_src <= '0;
            if (bus.process_iseq)
                ptr <= '0;
            if (acc_fwd) begin
                bus.fifo_en    <= NUM_FIFOS'(1) << ptr;
                bus.fifo_data  <= acc_word;
                bus.issued_src <= NUM_SRC'(1) << acc_idx;
                ptr            <= (ptr == FIW'(NUM_FIFOS - 1)) ? '0 : ptr + 1'b1;
                len_cnt        <= len_inc;
                if (len_inc == LEN_MAX)
                    bus.iseq_overflow <= 1'b1;
            end
            if (acc_end) begin
                // dropped END words do not count toward the length
                bus.process_iseq_src <= NUM_SRC'(1) << acc_idx;
                bus.iseq_len         <= acc_fwd ? len_inc : len_cnt;
                len_cnt              <= '0;
                state                <= S_IDLE;
`ifdef INSTR_RECV_RR_ARB_EN
                rr_base <= (acc_idx == SIW'(NUM_SRC - 1)) ? '0 : acc_idx + 1'b1;
`endif
            end else if (start) begin
                state <= S_BUSY;
                owner <= win_idx;
            end
        end
    end
endmodule

// File: tb/tb_instr_receiver_mc.sv
// tb/tb_instr_receiver_mc.sv - self-checking bench for instr_receiver_mc
module tb_instr_receiver_mc;
    localparam int IW = 32, NS = 2, NF = 2, LW = 10;
    localparam logic [3:0]    END_OP = 4'h4;
    localparam logic [NS-1:0] FWD    = 2'b01;
    localparam int            LMAX   = (1 << LW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          en_a [NS];
    logic [IW-1:0] wd   [NS];
    logic          dr, rde;
    logic [NF-1:0] full;

    instr_receiver_mc_if #(.INSTR_W(IW), .NUM_SRC(NS), .NUM_FIFOS(NF), .LEN_W(LW)) bus ();

    instr_receiver_mc #(
        .INSTR_W(IW), .NUM_SRC(NS), .NUM_FIFOS(NF), .END_OPCODE(END_OP),
        .FWD_END_MASK(FWD), .LEN_W(LW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    for (genvar i = 0; i < NS; i++) begin : g_src
        assign bus.src_en[i]            = en_a[i];
        assign bus.src_instr[i*IW +: IW] = wd[i];
    end
    assign bus.dispatcher_ready  = dr;
    assign bus.rdback_fifo_empty = rde;
    assign bus.fifo_full         = full;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int first_ack = -1;
    int last_len  = -1;
    logic [NF-1:0] en_log[$];
    logic [IW-1:0] data_log[$];
    logic [NS-1:0] pulse_log[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [IW-1:0] seq_word(input int i, input int n, input int tag);
        logic [3:0] op;
        op = (i == n - 1) ? END_OP : 4'((i % 3) + 1);
        return {op, 28'(tag + i)};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        en_log.delete();
        data_log.delete();
        pulse_log.delete();
        last_len = -1;
    endtask

    task automatic send_seq(input int s, input int n, input int tag);
        int  i, guard;
        bit  got;
        i = 0;
        guard = 0;
        while (i < n) begin
            wd[s]   = seq_word(i, n, tag);
            en_a[s] = 1'b1;
            @(negedge clk);
            got = bus.src_ack[s];
            @(posedge clk);
            #1;
            if (got) i++;
            guard++;
            if (guard > 100) begin
                n_tests++;
                n_fail++;
                $display("FAIL send timeout src %0d: acked %0d words required %0d", s, i, n);
                break;
            end
        end
        en_a[s] = 1'b0;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Spec-level model: who owns the iseq, which FIFO is next, how many words written.
    initial begin
        bit            on, m_busy, m_rd, e_pi, e_ovf, is_end, fwd;
        int            m_owner, m_ptr, m_cnt, m_rr, acc, idx;
        logic [NS-1:0] eack, e_src, e_pi_src;
        logic [NF-1:0] e_en;
        logic [IW-1:0] e_data, w;
        logic [LW-1:0] e_len;
        on = 0; m_busy = 0; m_rd = 1; e_pi = 0; e_ovf = 0;
        m_owner = 0; m_ptr = 0; m_cnt = 0; m_rr = 0;
        e_src = '0; e_pi_src = '0; e_en = '0; e_data = '0; e_len = '0;
        forever begin
            @(negedge clk);
            acc  = -1;
            eack = '0;
            if (!m_busy) begin
                if (dr && !e_pi && m_rd && !(|full) && (en_a[0] || en_a[1])) begin
                    for (int k = 0; k < NS; k++) begin
                        idx = (m_rr + k) % NS;
                        if (acc < 0 && en_a[idx]) acc = idx;
                    end
                end
            end else if (en_a[m_owner] && !(|full)) begin
                acc = m_owner;
            end
            if (acc >= 0) eack[acc] = 1'b1;
            if (on) begin
                chk("src_ack", bus.src_ack, eack);
                chk("fifo_en", bus.fifo_en, e_en);
                if (e_en != 0) begin
                    chk("fifo_data", bus.fifo_data, e_data);
                    chk("issued_instr", bus.issued_instr, e_data);
                end
                chk("issued_src", bus.issued_src, e_src);
                chk("process_iseq", bus.process_iseq, e_pi);
                if (e_pi) chk("process_iseq_src", bus.process_iseq_src, e_pi_src);
                chk("iseq_len", bus.iseq_len, e_len);
                chk("iseq_overflow", bus.iseq_overflow, e_ovf);
                if (bus.fifo_en != 0) begin
                    en_log.push_back(bus.fifo_en);
                    data_log.push_back(bus.fifo_data);
                end
                if (bus.process_iseq) begin
                    pulse_log.push_back(bus.process_iseq_src);
                    last_len = int'(bus.iseq_len);
                end
                if ((|bus.src_ack) && first_ack < 0) first_ack = cyc + 1;
            end
            if (rst) begin
                on = 1; m_busy = 0; m_rd = 1; e_pi = 0; e_ovf = 0;
                m_owner = 0; m_ptr = 0; m_cnt = 0; m_rr = 0;
                e_src = '0; e_pi_src = '0; e_en = '0; e_data = '0; e_len = '0;
            end else if (on) begin
                m_rd = rde;
                if (e_pi) m_ptr = 0;
                e_pi  = 0;
                e_en  = '0;
                e_src = '0;
                if (acc >= 0) begin
                    w      = wd[acc];
                    is_end = (w[IW-1 -: 4] == END_OP);
                    fwd    = !is_end || FWD[acc];
                    if (fwd) begin
                        e_en   = NF'(1) << m_ptr;
                        e_data = w;
                        e_src  = NS'(1) << acc;
                        m_ptr  = (m_ptr + 1) % NF;
                        m_cnt  = (m_cnt < LMAX) ? m_cnt + 1 : LMAX;
                        if (m_cnt == LMAX) e_ovf = 1;
                    end
                    if (is_end) begin
                        e_pi     = 1;
                        e_pi_src = NS'(1) << acc;
                        e_len    = LW'(m_cnt);
                        m_cnt    = 0;
                        m_busy   = 0;
`ifdef INSTR_RECV_RR_ARB_EN
                        m_rr     = (acc + 1) % NS;
`endif
                    end else begin
                        m_busy  = 1;
                        m_owner = acc;
                    end
                end
            end
        end
    end

    initial begin
        int raise_cyc, pulses_before;
        dr = 1'b1; rde = 1'b1; full = '0;
        for (int i = 0; i < NS; i++) begin
            en_a[i] = 1'b0;
            wd[i]   = '0;
        end
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        chk("reset fifo_en", bus.fifo_en, 0);
        chk("reset process_iseq", bus.process_iseq, 0);
        chk("reset iseq_len", bus.iseq_len, 0);
        tick(1);

        // source 0, END forwarded: three writes on FIFOs 0,1,0
        clear_logs();
        send_seq(0, 3, 'h100);
        tick(3);
        chk("A writes", en_log.size(), 3);
        chk("A en0", en_log[0], 2'b01);
        chk("A en1", en_log[1], 2'b10);
        chk("A en2", en_log[2], 2'b01);
        chk("A len", last_len, 3);
        chk("A src", pulse_log[0], 2'b01);

        // source 1, END dropped; pointer restarts at FIFO 0
        clear_logs();
        send_seq(1, 5, 'h200);
        tick(3);
        chk("B writes", en_log.size(), 4);
        chk("B en0", en_log[0], 2'b01);
        chk("B en3", en_log[3], 2'b10);
        chk("B last data", data_log[3], {4'h1, 28'h203});
        chk("B len", last_len, 4);
        chk("B src", pulse_log[0], 2'b10);

        // contention: source 0 has two iseqs queued, source 1 one
        clear_logs();
        fork
            begin
                send_seq(0, 2, 'h300);
                send_seq(0, 2, 'h310);
            end
            send_seq(1, 2, 'h400);
        join
        tick(3);
        chk("C pulses", pulse_log.size(), 3);
        chk("C first owner", pulse_log[0], 2'b01);
`ifdef INSTR_RECV_RR_ARB_EN
        chk("C second owner", pulse_log[1], 2'b10);
        chk("C third owner", pulse_log[2], 2'b01);
`else
        chk("C second owner", pulse_log[1], 2'b01);
        chk("C third owner", pulse_log[2], 2'b10);
`endif

        // fifo_full[1] for 4 cycles mid-iseq: no loss or reorder
        clear_logs();
        fork
            send_seq(0, 6, 'h500);
            begin
                tick(2);
                full = 2'b10;
                tick(4);
                full = '0;
            end
        join
        tick(3);
        chk("D writes", en_log.size(), 6);
        for (int i = 0; i < 6; i++) chk("D order", data_log[i], seq_word(i, 6, 'h500));
        chk("D len", last_len, 6);

        // dispatcher_ready gating: ack one edge after the rise
        dr = 1'b0;
        first_ack = -1;
        raise_cyc = 0;
        fork
            send_seq(0, 1, 'h600);
            begin
                tick(3);
                chk("E no ack while not ready", first_ack < 0, 1);
                raise_cyc = cyc;
                dr = 1'b1;
            end
        join
        tick(3);
        chk("E ready latency", first_ack - raise_cyc, 1);

        // rdback_fifo_empty gating: one extra register stage
        rde = 1'b0;
        tick(1);
        first_ack = -1;
        fork
            send_seq(0, 1, 'h700);
            begin
                tick(3);
                chk("F no ack while readback busy", first_ack < 0, 1);
                raise_cyc = cyc;
                rde = 1'b1;
            end
        join
        tick(3);
        chk("F rdback latency", first_ack - raise_cyc, 2);

        // reset two cycles into an iseq
        pulses_before = pulse_log.size();
        wd[0]   = seq_word(0, 5, 'h800);
        en_a[0] = 1'b1;
        tick(2);
        rst     = 1'b1;
        en_a[0] = 1'b0;
        tick(1);
        rst = 1'b0;
        chk("G reset fifo_en", bus.fifo_en, 0);
        chk("G reset issued_src", bus.issued_src, 0);
        tick(2);
        chk("G no pulse", pulse_log.size(), pulses_before);
        clear_logs();
        send_seq(0, 2, 'h900);
        tick(3);
        chk("G restart en0", en_log[0], 2'b01);
        chk("G restart len", last_len, 2);
        chk("G overflow", bus.iseq_overflow, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end
endmodule
